painterengine_gpu_job_scheduler: RTL and testbench

- Job queue and sequencer in front of the GPU renderer.
- Accepts render jobs from the register/CPU side into a small FIFO.
- Runs one job at a time: drives the renderer's configuration inputs, sequences its active-low reset, watches its state word for DONE or an error state, and enforces a timeout.
- Returns one completion record per job, carrying the job tag and a status code.

---
 rtl/painterengine_gpu_job_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_painterengine_gpu_job_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/painterengine_gpu_job_scheduler.sv
// Job FIFO and single-job sequencer for the PainterEngine GPU renderer: loads the
// renderer configuration, releases its reset, and reports a tag/status record per job.
module painterengine_gpu_job_scheduler #(
   parameter int unsigned QUEUE_DEPTH    = 4,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
   input  logic        i_wire_clock,
   input  logic        i_wire_reset,
   input  logic        i_wire_job_valid,
   output logic        o_wire_job_ready,
   input  logic [31:0] i_wire_job_src_address,
   input  logic [31:0] i_wire_job_dst_address,
   input  logic [31:0] i_wire_job_src_width,
   input  logic [31:0] i_wire_job_dst_width,
   input  logic [31:0] i_wire_job_xcount,
   input  logic [31:0] i_wire_job_ycount,
   input  logic        i_wire_job_rasterizer_mode,
   input  logic [7:0]  i_wire_job_tag,
   output logic        o_wire_renderer_resetn,
   output logic [31:0] o_wire_src_frame_buffer_address,
   output logic [31:0] o_wire_dst_frame_buffer_address,
   output logic [31:0] o_wire_src_frame_buffer_width,
   output logic [31:0] o_wire_dst_frame_buffer_width,
   output logic [31:0] o_wire_render_frame_buffer_xcount,
   output logic [31:0] o_wire_render_frame_buffer_ycount,
   output logic        o_wire_rasterizer_mode,
   input  logic [31:0] i_wire_renderer_state,
   output logic        o_wire_done_valid,
   input  logic        i_wire_done_ready,
   output logic [7:0]  o_wire_done_tag,
   output logic [1:0]  o_wire_done_status,
   output logic [7:0]  o_wire_queue_count,
   output logic        o_wire_busy
);

   localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
   localparam logic [4:0]  DEPTH = 5'(QUEUE_DEPTH);

   localparam logic [1:0] ST_OK        = 2'd0;
   localparam logic [1:0] ST_READ_ERR  = 2'd1;
   localparam logic [1:0] ST_WRITE_ERR = 2'd2;
   localparam logic [1:0] ST_TIMEOUT   = 2'd3;

   typedef struct packed {
      logic [31:0] src_address;
      logic [31:0] dst_address;
      logic [31:0] src_width;
      logic [31:0] dst_width;
      logic [31:0] xcount;
      logic [31:0] ycount;
      logic        rasterizer_mode;
   } cfg_t;

   typedef struct packed {
      cfg_t       cfg;
      logic [7:0] tag;
   } job_t;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, REPORT} state_e;

   state_e           state_q, state_d;
   job_t             queue_q [QUEUE_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [4:0]       count_q, count_d;
   cfg_t             cfg_q, cfg_d;
   logic [7:0]       tag_q, tag_d;
   logic [1:0]       status_q, status_d;
   logic             resetn_q, resetn_d;
   logic [31:0]      timer_q, timer_d;

   logic             push, pop;
   job_t             in_job, head_job;
   logic             head_zero;
   logic [7:0]       rstate;
   logic             unused_state_bits;

   assign in_job = {i_wire_job_src_address, i_wire_job_dst_address,
                    i_wire_job_src_width, i_wire_job_dst_width,
                    i_wire_job_xcount, i_wire_job_ycount,
                    i_wire_job_rasterizer_mode, i_wire_job_tag};

   assign o_wire_job_ready  = (count_q < DEPTH);
   assign push              = i_wire_job_valid && o_wire_job_ready;
   assign head_job          = queue_q[rd_ptr_q];
   assign head_zero         = (head_job.cfg.xcount == 32'd0) || (head_job.cfg.ycount == 32'd0);
   assign rstate            = i_wire_renderer_state[7:0];
   assign unused_state_bits = ^i_wire_renderer_state[31:8];

   // Queue storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge i_wire_clock) begin
      if (push) begin
         queue_q[wr_ptr_q] <= in_job;
      end
   end

   always_ff @(posedge i_wire_clock) begin
      if (i_wire_reset) begin
         state_q  <= IDLE;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         cfg_q    <= '0;
         tag_q    <= '0;
         status_q <= '0;
         resetn_q <= 1'b0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         cfg_q    <= cfg_d;
         tag_q    <= tag_d;
         status_q <= status_d;
         resetn_q <= resetn_d;
         timer_q  <= timer_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cfg_d    = cfg_q;
      tag_d    = tag_q;
      status_d = status_q;
      resetn_d = resetn_q;
      timer_d  = timer_q;
      pop      = 1'b0;

      unique case (state_q)
         IDLE: begin
            resetn_d = 1'b0;
            if (count_q != 5'd0) begin
               pop   = 1'b1;
               tag_d = head_job.tag;
               // Empty render areas complete immediately without touching the renderer.
               if (head_zero) begin
                  status_d = ST_OK;
                  state_d  = REPORT;
               end else begin
                  cfg_d   = head_job.cfg;
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            resetn_d = 1'b1;
            timer_d  = '0;
            state_d  = RUN;
         end
         RUN: begin
            state_d  = REPORT;
            resetn_d = 1'b0;
            // Terminal renderer states win over a timeout expiring in the same cycle.
            if (rstate == 8'h0B) begin
               status_d = ST_OK;
            end else if (rstate == 8'h0C || rstate == 8'h0D) begin
               status_d = ST_READ_ERR;
            end else if (rstate == 8'h0E) begin
               status_d = ST_WRITE_ERR;
            end else if (TIMEOUT_CYCLES != 32'd0 && timer_q == TIMEOUT_CYCLES - 32'd1) begin
               status_d = ST_TIMEOUT;
            end else begin
               state_d  = RUN;
               resetn_d = 1'b1;
               timer_d  = timer_q + 32'd1;
            end
         end
         REPORT: begin
            if (i_wire_done_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + 5'd1;
      end else if (pop && !push) begin
         count_d = count_q - 5'd1;
      end
   end

   assign o_wire_renderer_resetn            = resetn_q;
   assign o_wire_src_frame_buffer_address   = cfg_q.src_address;
   assign o_wire_dst_frame_buffer_address   = cfg_q.dst_address;
   assign o_wire_src_frame_buffer_width     = cfg_q.src_width;
   assign o_wire_dst_frame_buffer_width     = cfg_q.dst_width;
   assign o_wire_render_frame_buffer_xcount = cfg_q.xcount;
   assign o_wire_render_frame_buffer_ycount = cfg_q.ycount;
   assign o_wire_rasterizer_mode            = cfg_q.rasterizer_mode;
   assign o_wire_done_valid                 = (state_q == REPORT);
   assign o_wire_done_tag                   = tag_q;
   assign o_wire_done_status                = status_q;
   assign o_wire_queue_count                = {3'b000, count_q};
   assign o_wire_busy                       = (state_q != IDLE) || (count_q != 5'd0);

endmodule

// File: tb/tb_painterengine_gpu_job_scheduler.sv
// Bench for the GPU job scheduler: scripted renderer model, completion scoreboard,
// and a second instance with a short timeout.
module tb_painterengine_gpu_job_scheduler;

   typedef struct {
      logic [31:0] src, dst, srcW, dstW, xCount, yCount;
      logic        mode;
      logic [7:0]  tag;
      int          delay;
      logic [7:0]  code;
   } JobRec;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        jobValid = 1'b0, toValid = 1'b0;
   logic [31:0] jobSrc = '0, jobDst = '0, jobSrcW = '0, jobDstW = '0, jobX = '0, jobY = '0;
   logic        jobMode = 1'b0;
   logic [7:0]  jobTag = '0;
   logic        doneReady = 1'b0, toDoneReady = 1'b0;
   logic [31:0] rendState = '0;
   logic [31:0] toState = 32'h0000_0007;

   logic        jobReady, rendResetn, rastMode, doneValid, busy;
   logic [31:0] cfgSrc, cfgDst, cfgSrcW, cfgDstW, cfgX, cfgY;
   logic [7:0]  doneTag, queueCount;
   logic [1:0]  doneStatus;

   logic        toReady, toResetn, toDoneValid, toBusy, unusedToMode;
   logic [31:0] unusedToSrc, unusedToDst, unusedToSrcW, unusedToDstW, unusedToX, unusedToY;
   logic [7:0]  toDoneTag, unusedToCount;
   logic [1:0]  toDoneStatus;

   int          testsRun = 0, testsFailed = 0;
   int          cyc = 0, riseCount = 0, doneValidSeen = 0, lowRun = 100;
   logic        prevResetn = 1'b0;
   logic [192:0] cfgSnap = '0;
   JobRec       expCfg[$];
   logic [9:0]  expDone[$];

   painterengine_gpu_job_scheduler dut (
      .i_wire_clock(clk), .i_wire_reset(rst),
      .i_wire_job_valid(jobValid), .o_wire_job_ready(jobReady),
      .i_wire_job_src_address(jobSrc), .i_wire_job_dst_address(jobDst),
      .i_wire_job_src_width(jobSrcW), .i_wire_job_dst_width(jobDstW),
      .i_wire_job_xcount(jobX), .i_wire_job_ycount(jobY),
      .i_wire_job_rasterizer_mode(jobMode), .i_wire_job_tag(jobTag),
      .o_wire_renderer_resetn(rendResetn),
      .o_wire_src_frame_buffer_address(cfgSrc), .o_wire_dst_frame_buffer_address(cfgDst),
      .o_wire_src_frame_buffer_width(cfgSrcW), .o_wire_dst_frame_buffer_width(cfgDstW),
      .o_wire_render_frame_buffer_xcount(cfgX), .o_wire_render_frame_buffer_ycount(cfgY),
      .o_wire_rasterizer_mode(rastMode), .i_wire_renderer_state(rendState),
      .o_wire_done_valid(doneValid), .i_wire_done_ready(doneReady),
      .o_wire_done_tag(doneTag), .o_wire_done_status(doneStatus),
      .o_wire_queue_count(queueCount), .o_wire_busy(busy)
   );

   painterengine_gpu_job_scheduler #(.TIMEOUT_CYCLES(32'd100)) uTo (
      .i_wire_clock(clk), .i_wire_reset(rst),
      .i_wire_job_valid(toValid), .o_wire_job_ready(toReady),
      .i_wire_job_src_address(jobSrc), .i_wire_job_dst_address(jobDst),
      .i_wire_job_src_width(jobSrcW), .i_wire_job_dst_width(jobDstW),
      .i_wire_job_xcount(jobX), .i_wire_job_ycount(jobY),
      .i_wire_job_rasterizer_mode(jobMode), .i_wire_job_tag(jobTag),
      .o_wire_renderer_resetn(toResetn),
      .o_wire_src_frame_buffer_address(unusedToSrc), .o_wire_dst_frame_buffer_address(unusedToDst),
      .o_wire_src_frame_buffer_width(unusedToSrcW), .o_wire_dst_frame_buffer_width(unusedToDstW),
      .o_wire_render_frame_buffer_xcount(unusedToX), .o_wire_render_frame_buffer_ycount(unusedToY),
      .o_wire_rasterizer_mode(unusedToMode), .i_wire_renderer_state(toState),
      .o_wire_done_valid(toDoneValid), .i_wire_done_ready(toDoneReady),
      .o_wire_done_tag(toDoneTag), .o_wire_done_status(toDoneStatus),
      .o_wire_queue_count(unusedToCount), .o_wire_busy(toBusy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      testsRun++;
      if (act !== req) begin
         testsFailed++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic JobRec makeJob(input logic [31:0] src, dst, srcW, dstW, xCount, yCount,
                                     input logic mode, input logic [7:0] tag,
                                     input int delay, input logic [7:0] code);
      JobRec j;
      j.src = src; j.dst = dst; j.srcW = srcW; j.dstW = dstW;
      j.xCount = xCount; j.yCount = yCount; j.mode = mode; j.tag = tag;
      j.delay = delay; j.code = code;
      return j;
   endfunction

   function automatic JobRec randomJob(input logic [7:0] tag);
      JobRec j;
      logic [31:0] r;
      logic [7:0] codes [4] = '{8'h0B, 8'h0C, 8'h0D, 8'h0E};
      r = $urandom;
      j.src = $urandom; j.dst = $urandom; j.srcW = $urandom; j.dstW = $urandom;
      j.xCount = (r[1:0] == 2'd0) ? 32'd0 : $urandom;
      j.yCount = (r[3:2] == 2'd0) ? 32'd0 : $urandom;
      j.mode = r[4];
      j.tag = tag;
      j.delay = $urandom_range(1, 30);
      j.code = codes[$urandom_range(0, 3)];
      return j;
   endfunction

   // Reference outcome of a job, taken straight from the status rules.
   function automatic logic [1:0] refStatus(input JobRec j);
      if (j.xCount == 32'd0 || j.yCount == 32'd0) return 2'd0;
      case (j.code)
         8'h0B:        return 2'd0;
         8'h0C, 8'h0D: return 2'd1;
         8'h0E:        return 2'd2;
         default:      return 2'd3;
      endcase
   endfunction

   task automatic applyStimulus(input JobRec j, input int cap);
      bit acc = 1'b0;
      @(negedge clk);
      jobSrc = j.src; jobDst = j.dst; jobSrcW = j.srcW; jobDstW = j.dstW;
      jobX = j.xCount; jobY = j.yCount; jobMode = j.mode; jobTag = j.tag;
      jobValid = 1'b1;
      for (int c = 0; c < cap && !acc; c++) begin
         acc = jobReady;
         @(negedge clk);
      end
      jobValid = 1'b0;
      if (acc) begin
         expDone.push_back({j.tag, refStatus(j)});
         if (j.xCount != 32'd0 && j.yCount != 32'd0) expCfg.push_back(j);
      end else begin
         check("push_accept_timeout", jobReady, 1'b1);
      end
   endtask

   task automatic waitIdle(input int cap);
      bit ok = 1'b0;
      for (int c = 0; c < cap && !ok; c++) begin
         @(negedge clk);
         #4;
         ok = !busy && (expDone.size() == 0);
      end
      check("drain_to_idle", ok, 1'b1);
   endtask

   // Scoreboard monitor and renderer-reset observer, sampled late in the low clock phase.
   always @(negedge clk) begin
      #3;
      if (doneValid) doneValidSeen++;
      if (doneValid && doneReady) begin
         if (expDone.size() == 0) begin
            check("done_without_job", doneValid, 1'b0);
         end else begin
            logic [9:0] e;
            e = expDone.pop_front();
            check("checkOutput_done_record", {doneTag, doneStatus}, e);
         end
      end
      if (rendResetn && !prevResetn) begin
         riseCount++;
         check("resetn_low_gap_ok", lowRun >= 2, 1'b1);
      end
      lowRun     = rendResetn ? 0 : lowRun + 1;
      prevResetn = rendResetn;
      cfgSnap    = {cfgSrc, cfgDst, cfgSrcW, cfgDstW, cfgX, cfgY, rastMode};
   end

   // Renderer model: on each reset release, play the job's script for its final state.
   initial begin
      JobRec j;
      logic [31:0] upper;
      bit aborted;
      wait (rst == 1'b0);
      forever begin
         @(posedge rendResetn);
         if (expCfg.size() == 0) begin
            check("renderer_start_without_job", rendResetn, 1'b0);
         end else begin
            j = expCfg.pop_front();
            check("checkOutput_config_before_release", cfgSnap,
                  {j.src, j.dst, j.srcW, j.dstW, j.xCount, j.yCount, j.mode});
            aborted = 1'b0;
            for (int k = 0; k < j.delay && !aborted; k++) begin
               @(negedge clk);
               if (!rendResetn) aborted = 1'b1;
            end
            upper = $urandom;
            if (!aborted) rendState = {upper[31:8], j.code};
            while (rendResetn) @(negedge clk);
            rendState = '0;
         end
      end
   end

   initial begin
      int riseBefore, seenBefore, riseCyc, doneCyc;
      bit got;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_count", queueCount, 8'd0);
      check("reset_ready", jobReady, 1'b1);
      check("reset_resetn", rendResetn, 1'b0);
      check("reset_done_valid", doneValid, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_config", {cfgSrc, cfgDst, cfgSrcW, cfgDstW, cfgX, cfgY, rastMode, doneTag, doneStatus}, '0);
      check("reset_to_ready", toReady, 1'b1);

      doneReady = 1'b1;
      applyStimulus(makeJob(32'h1000, 32'h8000, 32'd640, 32'd640, 32'd64, 32'd2, 1'b0, 8'h11, 200, 8'h0B), 50);
      waitIdle(1000);
      check("busy_after_done", busy, 1'b0);

      doneReady = 1'b0;
      applyStimulus(makeJob(32'h100, 32'h200, 32'd16, 32'd16, 32'd4, 32'd4, 1'b1, 8'h41, 5, 8'h0D), 50);
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clk);
         got = doneValid;
      end
      check("first_done_pending", got, 1'b1);
      applyStimulus(makeJob(32'h300, 32'h400, 32'd8, 32'd8, 32'd2, 32'd3, 1'b0, 8'h42, 3, 8'h0E), 50);
      applyStimulus(makeJob(32'h500, 32'h600, 32'd8, 32'd8, 32'd2, 32'd2, 1'b1, 8'h43, 2, 8'h0B), 50);
      applyStimulus(makeJob(32'h700, 32'h800, 32'd8, 32'd8, 32'd1, 32'd1, 1'b0, 8'h44, 4, 8'h0B), 50);
      applyStimulus(makeJob(32'h900, 32'hA00, 32'd8, 32'd8, 32'd3, 32'd1, 1'b1, 8'h45, 5, 8'h0B), 50);
      check("queue_full_count", queueCount, 8'd4);
      check("queue_full_ready", jobReady, 1'b0);
      fork
         applyStimulus(makeJob(32'hB00, 32'hC00, 32'd8, 32'd8, 32'd5, 32'd5, 1'b0, 8'h46, 3, 8'h0B), 200);
         begin
            repeat (8) @(negedge clk);
            check("fifth_stalled_count", queueCount, 8'd4);
            doneReady = 1'b1;
         end
      join
      waitIdle(2000);

      @(negedge clk);
      jobSrc = 32'h1; jobDst = 32'h2; jobSrcW = 32'd4; jobDstW = 32'd4;
      jobX = 32'd5; jobY = 32'd5; jobMode = 1'b0; jobTag = 8'h31;
      toValid = 1'b1;
      @(negedge clk);
      toValid = 1'b0;
      riseCyc = -1;
      doneCyc = -1;
      for (int c = 0; c < 400 && doneCyc < 0; c++) begin
         @(negedge clk);
         if (toResetn && riseCyc < 0) riseCyc = cyc;
         if (toDoneValid) begin
            doneCyc = cyc;
            check("timeout_resetn_low", toResetn, 1'b0);
            check("timeout_record", {toDoneTag, toDoneStatus}, {8'h31, 2'd3});
         end
      end
      check("timeout_latency", doneCyc - riseCyc, 100);
      toDoneReady = 1'b1;
      repeat (2) @(negedge clk);
      check("timeout_idle", toBusy, 1'b0);

      riseBefore = riseCount;
      applyStimulus(makeJob(32'h10, 32'h20, 32'd8, 32'd8, 32'd0, 32'd7, 1'b0, 8'h21, 1, 8'h0E), 50);
      applyStimulus(makeJob(32'h30, 32'h40, 32'd8, 32'd8, 32'd7, 32'd0, 1'b1, 8'h22, 1, 8'h0E), 50);
      waitIdle(200);
      check("zero_size_no_start", riseCount, riseBefore);

      applyStimulus(makeJob(32'h50, 32'h60, 32'd8, 32'd8, 32'd9, 32'd9, 1'b0, 8'h51, 1000, 8'h0B), 50);
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         got = rendResetn;
      end
      check("abort_job_running", got, 1'b1);
      applyStimulus(makeJob(32'h70, 32'h80, 32'd8, 32'd8, 32'd2, 32'd2, 1'b0, 8'h52, 3, 8'h0B), 50);
      applyStimulus(makeJob(32'h90, 32'hA0, 32'd8, 32'd8, 32'd2, 32'd2, 1'b0, 8'h53, 3, 8'h0B), 50);
      check("abort_queued", queueCount, 8'd2);
      seenBefore = doneValidSeen;
      rst = 1'b1;
      expDone.delete();
      expCfg.delete();
      @(negedge clk);
      rst = 1'b0;
      check("abort_count", queueCount, 8'd0);
      check("abort_resetn", rendResetn, 1'b0);
      check("abort_done_valid", doneValid, 1'b0);
      check("abort_ready", jobReady, 1'b1);
      repeat (50) @(negedge clk);
      check("abort_no_completion", doneValidSeen, seenBefore);
      check("abort_idle", busy, 1'b0);

      fork
         begin
            for (int n = 0; n < 24; n++) begin
               applyStimulus(randomJob(8'(8'h80 + n)), 2000);
               repeat ($urandom_range(0, 3)) @(negedge clk);
            end
         end
         begin
            for (int c = 0; c < 1200; c++) begin
               @(negedge clk);
               doneReady = ($urandom_range(0, 2) != 0);
            end
         end
      join
      doneReady = 1'b1;
      waitIdle(3000);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
